// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes and row/column to code map for the keypad scanner
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Telephone layout: rows 0..2 hold 1..9, row 3 holds * 0 #
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case (row)
            2'd0: code = {2'b00, col} + 4'd1;
            2'd1: code = {2'b00, col} + 4'd4;
            2'd2: code = {2'b00, col} + 4'd7;
            default: begin
                case (col)
                    2'd0:    code = KEY_STAR;
                    2'd1:    code = 4'd0;
                    default: code = KEY_HASH;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - accepts a frame code once it repeats for DEBOUNCE consecutive frames
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic [3:0] frame_code,
    output logic [3:0] stable
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (frame_code == cand) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end
    end

    // A fresh candidate starts at zero, so DEBOUNCE=1 accepts it on the same frame
    always_ff @(posedge clk) begin
        if (rst) begin
            cand   <= KEY_NONE;
            cnt    <= '0;
            stable <= KEY_NONE;
        end else if (frame_done) begin
            cand <= frame_code;
            cnt  <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                stable <= frame_code;
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x3 keypad column scanner with row sync, multi-key reject and debounced outputs
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_press
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col_idx;
    logic          sample;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    logic [1:0]    hits_cnt;
    logic [3:0]    hits_code;
    logic          frame_done;
    logic [3:0]    frame_code;
    logic [3:0]    stable;
    logic [3:0]    prev_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    assign sample  = (div_cnt == DIV_MAX);
    assign key_col = ~(3'b001 << col_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Column 0 starts a new frame, so the running tally is ignored there
    always_comb begin
        hits_cnt  = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
        hits_code = (col_idx == 2'd0) ? KEY_NONE : acc_code;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (hits_cnt != 2'd2) begin
                    hits_cnt = hits_cnt + 2'd1;
                end
                hits_code = key_map(2'(r), col_idx);
            end
        end
    end

    assign frame_done = sample && (col_idx == 2'd2);
    assign frame_code = (hits_cnt == 2'd1) ? hits_code : KEY_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= 2'd0;
            acc_code <= KEY_NONE;
        end else if (sample) begin
            acc_cnt  <= hits_cnt;
            acc_code <= hits_code;
        end
    end

    keypad_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_done(frame_done),
        .frame_code(frame_code),
        .stable    (stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_stable <= KEY_NONE;
        end else begin
            prev_stable <= stable;
        end
    end

    assign keypad    = (stable <= 4'd9) ? (10'd1 << stable) : 10'd0;
    assign key_star  = (stable == KEY_STAR);
    assign key_hash  = (stable == KEY_HASH);
    assign key_press = (stable != prev_stable) && (stable != KEY_NONE);

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with an emulated keypad and frame-level model
module tb_keypad_scan;

    localparam int SD    = 3;
    localparam int DB    = 2;
    localparam int FRAME = 3 * SD;
    localparam int NONE  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_press;

    logic [11:0] held = '0;
    int total = 0;
    int bad = 0;
    int phase = 0;
    int exp_stable = NONE;
    int exp_press = 0;
    int frame_codes[$];
    int code_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    keypad_scan #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .keypad   (keypad),
        .key_star (key_star),
        .key_hash (key_hash),
        .key_press(key_press)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key pulls its row low while its column is driven low
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (held[r*3+c] && (key_col[c] === 1'b0)) key_row[r] = 1'b0;
            end
        end
    end

    function automatic int frame_code_of(input logic [11:0] h);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (h[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? code_of[idx] : NONE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        logic [2:0] ecol;
        logic [9:0] ekey;
        int fc;
        bit same;
        @(posedge clk);
        #1;
        exp_press = 0;
        if (rst) begin
            phase = 0;
            frame_codes.delete();
            exp_stable = NONE;
        end else begin
            phase++;
            if (phase == FRAME) begin
                phase = 0;
                fc = frame_code_of(held);
                frame_codes.push_back(fc);
                if (frame_codes.size() >= DB) begin
                    same = 1'b1;
                    for (int k = 1; k < DB; k++) begin
                        if (frame_codes[frame_codes.size()-1-k] != fc) same = 1'b0;
                    end
                    if (same && fc != exp_stable) begin
                        exp_press = (fc != NONE) ? 1 : 0;
                        exp_stable = fc;
                    end
                end
            end
        end
        ecol = ~(3'b001 << (phase / SD));
        ekey = (exp_stable <= 9) ? (10'd1 << exp_stable) : 10'd0;
        check("key_col", 32'(key_col), 32'(ecol));
        check("keypad", 32'(keypad), 32'(ekey));
        check("key_star", 32'(key_star), 32'(exp_stable == 10));
        check("key_hash", 32'(key_hash), 32'(exp_stable == 11));
        check("key_press", 32'(key_press), 32'(exp_press));
    endtask

    task automatic run_frames(input logic [11:0] h, input int n);
        held = h;
        repeat (n * FRAME) cycle();
    endtask

    function automatic logic [11:0] pos(input int p);
        logic [11:0] m = '0;
        m[p] = 1'b1;
        return m;
    endfunction

    initial begin
        int a;
        int b;
        int n;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        run_frames('0, 6);

        run_frames(pos(4), 2);
        check("digit5_at_cycle18", 32'(keypad), 32'(10'b0000100000));
        check("digit5_press", 32'(key_press), 32'd1);
        run_frames(pos(4), 2);
        run_frames('0, 3);

        run_frames(pos(10) | pos(7), 4);
        run_frames('0, 2);

        run_frames(pos(11), 3);
        run_frames(pos(9), 3);
        run_frames('0, 3);

        for (int i = 0; i < 10; i++) begin
            run_frames((i % 2 == 0) ? pos(2) : 12'd0, 1);
        end
        run_frames(pos(2), 3);
        run_frames('0, 3);

        run_frames(pos(6), 1);
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("reset_keycol", 32'(key_col), 32'(3'b110));
        check("reset_keypad", 32'(keypad), 32'd0);
        run_frames(pos(6), 2);
        check("digit7_after_reset", 32'(keypad), 32'(10'b0010000000));
        run_frames(pos(6), 1);
        run_frames('0, 2);

        for (int i = 0; i < 30; i++) begin
            a = $urandom_range(0, 11);
            b = $urandom_range(0, 11);
            n = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0:       run_frames('0, n);
                3:       run_frames(pos(a) | pos(b), n);
                default: run_frames(pos(a), n);
            endcase
        end
        run_frames('0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
